// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption sequencer: one shared round datapath stepped NUM_ROUNDS times per block.
// Optional feature macro: AES_SEQ_FLUSH_EN adds a flush input that aborts the block in flight.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_SEQ_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   key_round,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] FINAL_RND = 4'(NUM_ROUNDS);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            else       p = p;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box as x^254 (the GF(2^8) inverse, 0 -> 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [127:0]   st_r, st_nxt_s;
    logic [3:0]     rnd_r, rnd_nxt_s;
    logic [127:0]   sb_sr_s, mc_s;
    logic           flush_s, accept_s;

`ifdef AES_SEQ_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign sb_sr_s   = shift_rows(sub_bytes(st_r));
    assign mc_s      = mix_columns(sb_sr_s);
    assign in_ready  = rst_n && !flush_s && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == ROUND) || (state_r == FINAL);
    assign out_block = st_r;

    // Key index decode; the key store answers combinationally in the same cycle.
    always_comb begin
        key_round = 4'd0;
        case (state_r)
            ROUND:   key_round = rnd_r;
            FINAL:   key_round = FINAL_RND;
            default: key_round = 4'd0;
        endcase
    end

    // Next-state and datapath select; flush keeps st but aborts everything else.
    always_comb begin
        state_nxt_s = state_r;
        st_nxt_s    = st_r;
        rnd_nxt_s   = rnd_r;
        if (flush_s) begin
            state_nxt_s = IDLE;
            rnd_nxt_s   = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        st_nxt_s    = in_block ^ round_key;
                        rnd_nxt_s   = 4'd1;
                        state_nxt_s = ROUND;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ROUND: begin
                    st_nxt_s  = mc_s ^ round_key;
                    rnd_nxt_s = rnd_r + 4'd1;
                    if (rnd_r == LAST_RND) state_nxt_s = FINAL;
                    else                   state_nxt_s = ROUND;
                end
                FINAL: begin
                    st_nxt_s    = sb_sr_s ^ round_key;
                    state_nxt_s = DONE;
                end
                DONE: begin
                    if (out_ready && accept_s) begin
                        st_nxt_s    = in_block ^ round_key;
                        rnd_nxt_s   = 4'd1;
                        state_nxt_s = ROUND;
                    end else if (out_ready) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    rnd_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // State, block and round-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            st_r    <= 128'h0;
            rnd_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            st_r    <= st_nxt_s;
            rnd_r   <= rnd_nxt_s;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer using FIPS-197 vectors; flush cases run when AES_SEQ_FLUSH_EN is defined.
module tb_aes_round_sequencer;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = 128'h0;
    logic [3:0]   key_round;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef AES_SEQ_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_block(in_block),
        .key_round(key_round),
        .round_key(round_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_block(out_block),
        .busy(busy)
    );

    logic [127:0] pt_v [2];
    logic [127:0] ct_v [2];
    logic [127:0] key_v [2];
    logic [127:0] rk [2][11];
    int offer_set = 0;
    int run_set = 0;

    // Key store: index 0 belongs to the block being offered, others to the block in flight.
    always_comb begin
        if (key_round == 4'd0) round_key = rk[offer_set][0];
        else if (key_round <= 4'd10) round_key = rk[run_set][key_round];
        else round_key = 128'h0;
    end

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] c = 8'h63;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic expand(input int v);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key_v[v][127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = tb_mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[v][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [127:0] ct;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    int   hs_cyc[$];
    int   cyc = 0;
    int   acc_cnt = 0;
    int   last_acc = 0;
    bit   inflight = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every cycle against the model, pops on handshakes, pushes on acceptances.
    always @(negedge clk) begin : mon
        int p;
        if (!rst_n || flush) begin
            chk("in_ready_abort", 128'(in_ready), 128'd0);
            inflight = 1'b0;
            sbq.delete();
        end else begin
            p = cyc - last_acc;
            if (inflight && p < NR) begin
                chk("busy_run", 128'(busy), 128'd1);
                chk("ov_run", 128'(out_valid), 128'd0);
                chk("key_round_run", 128'(key_round), 128'(p + 1));
                chk("in_ready_run", 128'(in_ready), 128'd0);
            end else if (inflight) begin
                chk("ov_done", 128'(out_valid), 128'd1);
                chk("busy_done", 128'(busy), 128'd0);
                chk("key_round_done", 128'(key_round), 128'd0);
                chk("in_ready_done", 128'(in_ready), 128'(out_ready));
                if (sbq.size() > 0) chk("out_block", out_block, sbq[0].ct);
                if (out_valid && out_ready) begin
                    if (sbq.size() > 0) void'(sbq.pop_front());
                    hs_cyc.push_back(cyc);
                    inflight = 1'b0;
                end
            end else begin
                chk("ov_idle", 128'(out_valid), 128'd0);
                chk("busy_idle", 128'(busy), 128'd0);
                chk("in_ready_idle", 128'(in_ready), 128'd1);
                chk("key_round_idle", 128'(key_round), 128'd0);
            end
            if (in_valid && in_ready) begin
                sbq.push_back('{ct: ct_v[offer_set], acc: cyc + 1});
                last_acc = cyc + 1;
                run_set  = offer_set;
                inflight = 1'b1;
                acc_cnt++;
            end
        end
    end

    task automatic send(input int v, input bit hold);
        int start = acc_cnt;
        bit ok = 1'b0;
        in_block  = pt_v[v];
        offer_set = v;
        in_valid  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != start) begin ok = 1'b1; break; end
        end
        if (!hold) in_valid = 1'b0;
        chk("accept_timeout", 128'(ok), 128'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (!inflight && sbq.size() == 0) begin ok = 1'b1; break; end
        end
        chk("idle_timeout", 128'(ok), 128'd1);
    endtask

    task automatic wait_kr(input logic [3:0] k);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (key_round == k) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("key_round_wait_timeout", 128'(ok), 128'd1);
    endtask

    task automatic wait_ov();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("out_valid_timeout", 128'(ok), 128'd1);
    endtask

    initial begin
        pt_v[0]  = 128'h3243f6a8885a308d313198a2e0370734;
        key_v[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ct_v[0]  = 128'h3925841d02dc09fbdc118597196a0b32;
        pt_v[1]  = 128'h00112233445566778899aabbccddeeff;
        key_v[1] = 128'h000102030405060708090a0b0c0d0e0f;
        ct_v[1]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        expand(0);
        expand(1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_key_round", 128'(key_round), 128'd0);
        chk("rst_st", out_block, 128'h0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        send(0, 1'b0);
        wait_idle();
        send(1, 1'b0);
        wait_idle();

        // Back-pressure: hold DONE for five cycles, then release.
        out_ready = 1'b0;
        send(0, 1'b0);
        wait_ov();
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;

        // Back-to-back: second block accepted in the first block's DONE cycle.
        hs_cyc.delete();
        send(0, 1'b1);
        send(1, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        chk("b2b_count", 128'(hs_cyc.size()), 128'd2);
        if (hs_cyc.size() == 2) chk("b2b_spacing", 128'(hs_cyc[1] - hs_cyc[0]), 128'd11);

        // Reset in the middle of round 5.
        send(0, 1'b0);
        wait_kr(4'd5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
        chk("mid_rst_st", out_block, 128'h0);
        rst_n = 1'b1;
        send(0, 1'b0);
        wait_idle();

`ifdef AES_SEQ_FLUSH_EN
        send(1, 1'b0);
        wait_kr(4'd7);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 128'(busy), 128'd0);
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        send(0, 1'b0);
        wait_idle();

        out_ready = 1'b0;
        send(0, 1'b0);
        wait_ov();
        out_ready = 1'b1;
        in_block  = pt_v[1];
        offer_set = 1;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_done_out_valid", 128'(out_valid), 128'd0);
        chk("flush_done_busy", 128'(busy), 128'd0);
        send(1, 1'b0);
        wait_idle();
`endif

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
